// File: rtl/first_n_clusters_pkg.sv
// rtl/first_n_clusters_pkg.sv - shared state enum, default parameters and constants for first_n_clusters
package first_n_clusters_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        MERGE   = 2'd2,
        PUBLISH = 2'd3
    } state_e;

    localparam int DEF_MXSBITS   = 1536;
    localparam int DEF_NPART     = 2;
    localparam int DEF_NCLUST    = 8;
    localparam int DEF_MXADRBITS = 11;
    localparam int DEF_MXCNTBITS = 3;

    localparam logic [DEF_MXADRBITS-1:0] EMPTY_ADR = '1;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/first_n_clusters_if.sv
// rtl/first_n_clusters_if.sv - latch request and cluster result bundle for first_n_clusters
interface first_n_clusters_if
    import first_n_clusters_pkg::*;
#(
    parameter int MXSBITS   = DEF_MXSBITS,
    parameter int NCLUST    = DEF_NCLUST,
    parameter int MXADRBITS = DEF_MXADRBITS,
    parameter int MXCNTBITS = DEF_MXCNTBITS
);
    logic [3:0]                     latch_delay;
    logic                           latch_in;
    logic [MXSBITS-1:0]             vpfs;
    logic [MXSBITS*MXCNTBITS-1:0]   cnts;
    logic [NCLUST*MXADRBITS-1:0]    adr;
    logic [NCLUST*MXCNTBITS-1:0]    cnt;
    logic [NCLUST-1:0]              vld;
    logic                           done;
    logic                           drop;
    logic                           overflow;

    modport master (
        output latch_delay, latch_in, vpfs, cnts,
        input  adr, cnt, vld, done, drop, overflow
    );

    modport slave (
        input  latch_delay, latch_in, vpfs, cnts,
        output adr, cnt, vld, done, drop, overflow
    );
endinterface

// File: rtl/first_n_clusters_partition_scanner.sv
// rtl/first_n_clusters_partition_scanner.sv - iterative find-first-and-clear encoder for one partition
module partition_scanner #(
    parameter int W      = 768,
    parameter int LW     = 10,
    parameter int CW     = 3,
    parameter int NCLUST = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         step,
    input  logic [W-1:0]                 vpf_in,
    input  logic [W*CW-1:0]              cnt_in,
    output logic [NCLUST-1:0][LW-1:0]    idx_o,
    output logic [NCLUST-1:0][CW-1:0]    cnt_o,
    output logic [NCLUST-1:0]            fnd_o,
    output logic                         left_o
);
    logic [W-1:0]              work_q, work_d;
    logic [W*CW-1:0]           snap_cnt_q, snap_cnt_d;
    logic [NCLUST-1:0][LW-1:0] idx_q, idx_d;
    logic [NCLUST-1:0][CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [NCLUST-1:0]         fnd_q, fnd_d;
    logic [LW-1:0]             low_idx;
    logic [CW-1:0]             low_cnt;

    // descending walk so the last hit is the lowest set bit
    always_comb begin
        low_idx = '0;
        low_cnt = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (work_q[i]) begin
                low_idx = LW'(i);
                low_cnt = snap_cnt_q[i*CW +: CW];
            end
        end
    end

    // results enter at the top slot, so after NCLUST steps the first find sits in slot 0
    always_comb begin
        work_d     = work_q;
        snap_cnt_d = snap_cnt_q;
        idx_d      = idx_q;
        slot_cnt_d = slot_cnt_q;
        fnd_d      = fnd_q;
        if (load) begin
            work_d     = vpf_in;
            snap_cnt_d = cnt_in;
            idx_d      = '0;
            slot_cnt_d = '0;
            fnd_d      = '0;
        end else if (step) begin
            work_d     = work_q & (work_q - W'(1));
            idx_d      = {low_idx, idx_q[NCLUST-1:1]};
            slot_cnt_d = {low_cnt, slot_cnt_q[NCLUST-1:1]};
            fnd_d      = {(|work_q), fnd_q[NCLUST-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q     <= '0;
            snap_cnt_q <= '0;
            idx_q      <= '0;
            slot_cnt_q <= '0;
            fnd_q      <= '0;
        end else begin
            work_q     <= work_d;
            snap_cnt_q <= snap_cnt_d;
            idx_q      <= idx_d;
            slot_cnt_q <= slot_cnt_d;
            fnd_q      <= fnd_d;
        end
    end

    assign idx_o  = idx_q;
    assign cnt_o  = slot_cnt_q;
    assign fnd_o  = fnd_q;
    assign left_o = |work_q;
endmodule

// File: rtl/first_n_clusters.sv
// rtl/first_n_clusters.sv - reports the first NCLUST clusters per latch; FIRST_N_OVERFLOW_EN enables overflow
module first_n_clusters
    import first_n_clusters_pkg::*;
#(
    parameter int MXSBITS   = DEF_MXSBITS,
    parameter int NPART     = DEF_NPART,
    parameter int NCLUST    = DEF_NCLUST,
    parameter int MXADRBITS = DEF_MXADRBITS,
    parameter int MXCNTBITS = DEF_MXCNTBITS
) (
    input  logic                           clock4x,
    input  logic                           global_reset_n,
    input  logic [3:0]                     latch_delay,
    input  logic                           latch_in,
    input  logic [MXSBITS-1:0]             vpfs_in,
    input  logic [MXSBITS*MXCNTBITS-1:0]   cnts_in,
    output logic [NCLUST*MXADRBITS-1:0]    adr_out,
    output logic [NCLUST*MXCNTBITS-1:0]    cnt_out,
    output logic [NCLUST-1:0]              vld_out,
    output logic                           done_out,
    output logic                           latch_drop,
    output logic                           overflow
);
    localparam int PW   = MXSBITS / NPART;
    localparam int LW   = clog2_min1(PW);
    localparam int CTRW = clog2_min1((NCLUST > NPART) ? NCLUST : NPART);
    localparam int PSW  = clog2_min1(NPART);
    localparam int IW   = clog2_min1(NCLUST);
    localparam int MW   = $clog2(NCLUST + 1);
    localparam logic [MXADRBITS-1:0] EMPTY_A = {MXADRBITS{EMPTY_ADR[0]}};

    logic [14:0] dly_q, dly_d;
    logic [15:0] taps;
    logic        cap_req;
    state_e      state_q, state_d;
    logic [CTRW-1:0] ctr_q, ctr_d;
    logic [PSW-1:0]  psel;
    logic load, step, merge_en, publish, drop;

    // tap 0 is latch_in itself so latch_delay 0 captures on the sampling edge
    assign taps    = {dly_q, latch_in};
    assign cap_req = taps[latch_delay];
    assign psel    = ctr_q[PSW-1:0];

    always_comb begin
        dly_d = taps[14:0];
    end

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            dly_q   <= '0;
            state_q <= IDLE;
            ctr_q   <= '0;
        end else begin
            dly_q   <= dly_d;
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        unique case (state_q)
            IDLE: if (cap_req) begin state_d = SCAN; ctr_d = '0; end
            SCAN: begin
                if (ctr_q == CTRW'(NCLUST - 1)) begin state_d = MERGE; ctr_d = '0; end
                else ctr_d = ctr_q + CTRW'(1);
            end
            MERGE: begin
                if (ctr_q == CTRW'(NPART - 1)) begin state_d = PUBLISH; ctr_d = '0; end
                else ctr_d = ctr_q + CTRW'(1);
            end
            PUBLISH: begin
                state_d = cap_req ? SCAN : IDLE;
                ctr_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        step     = 1'b0;
        merge_en = 1'b0;
        publish  = 1'b0;
        drop     = 1'b0;
        unique case (state_q)
            IDLE:    load = cap_req;
            SCAN:    begin step = 1'b1;     drop = cap_req; end
            MERGE:   begin merge_en = 1'b1; drop = cap_req; end
            PUBLISH: begin publish = 1'b1;  load = cap_req; end
            default: ;
        endcase
    end

    logic [NPART-1:0][NCLUST-1:0][LW-1:0]        sc_idx;
    logic [NPART-1:0][NCLUST-1:0][MXCNTBITS-1:0] sc_cnt;
    logic [NPART-1:0][NCLUST-1:0]                sc_fnd;
    logic [NPART-1:0]                            sc_left;

    for (genvar p = 0; p < NPART; p++) begin : g_part
        partition_scanner #(.W(PW), .LW(LW), .CW(MXCNTBITS), .NCLUST(NCLUST)) u_scan (
            .clk    (clock4x),
            .rst_n  (global_reset_n),
            .load   (load),
            .step   (step),
            .vpf_in (vpfs_in[p*PW +: PW]),
            .cnt_in (cnts_in[p*PW*MXCNTBITS +: PW*MXCNTBITS]),
            .idx_o  (sc_idx[p]),
            .cnt_o  (sc_cnt[p]),
            .fnd_o  (sc_fnd[p]),
            .left_o (sc_left[p])
        );
    end

    logic [NCLUST-1:0][MXADRBITS-1:0] madr_q, madr_d, adr_q, adr_d;
    logic [NCLUST-1:0][MXCNTBITS-1:0] mcnt_q, mcnt_d, cnt_q, cnt_d;
    logic [NCLUST-1:0]                mvld_q, mvld_d, vld_q, vld_d;
    logic [MW-1:0]                    mn_q, mn_d;
    logic                             done_q, done_d, drop_q, drop_d;

    // found entries form a prefix, so appending in slot order keeps addresses ascending
    always_comb begin
        madr_d = madr_q;
        mcnt_d = mcnt_q;
        mvld_d = mvld_q;
        mn_d   = mn_q;
        if (load) begin
            madr_d = {NCLUST{EMPTY_A}};
            mcnt_d = '0;
            mvld_d = '0;
            mn_d   = '0;
        end else if (merge_en) begin
            for (int j = 0; j < NCLUST; j++) begin
                if (sc_fnd[psel][j] && (int'(mn_d) < NCLUST)) begin
                    madr_d[mn_d[IW-1:0]] = MXADRBITS'(int'(psel) * PW + int'(sc_idx[psel][j]));
                    mcnt_d[mn_d[IW-1:0]] = sc_cnt[psel][j];
                    mvld_d[mn_d[IW-1:0]] = 1'b1;
                    mn_d = mn_d + MW'(1);
                end
            end
        end
    end

    always_comb begin
        adr_d  = publish ? madr_q : adr_q;
        cnt_d  = publish ? mcnt_q : cnt_q;
        vld_d  = publish ? mvld_q : vld_q;
        done_d = publish;
        drop_d = drop;
    end

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            madr_q <= {NCLUST{EMPTY_A}};
            mcnt_q <= '0;
            mvld_q <= '0;
            mn_q   <= '0;
            adr_q  <= {NCLUST{EMPTY_A}};
            cnt_q  <= '0;
            vld_q  <= '0;
            done_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            madr_q <= madr_d;
            mcnt_q <= mcnt_d;
            mvld_q <= mvld_d;
            mn_q   <= mn_d;
            adr_q  <= adr_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            done_q <= done_d;
            drop_q <= drop_d;
        end
    end

    assign adr_out    = adr_q;
    assign cnt_out    = cnt_q;
    assign vld_out    = vld_q;
    assign done_out   = done_q;
    assign latch_drop = drop_q;

`ifdef FIRST_N_OVERFLOW_EN
    logic spill;
    logic mspill_q, mspill_d, ovf_q, ovf_d;

    // spill: this partition's finds would not fit in the remaining merge slots
    always_comb begin
        int nf;
        nf = 0;
        for (int j = 0; j < NCLUST; j++) nf += int'(sc_fnd[psel][j]);
        spill = (int'(mn_q) + nf) > NCLUST;
    end

    always_comb begin
        mspill_d = mspill_q;
        ovf_d    = ovf_q;
        if (load) mspill_d = 1'b0;
        else if (merge_en && spill) mspill_d = 1'b1;
        if (publish) ovf_d = (|sc_left) | mspill_q;
    end

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            mspill_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mspill_q <= mspill_d;
            ovf_q    <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_left;
    assign unused_left = ^sc_left;
    assign overflow    = 1'b0;
`endif
endmodule

// File: tb/tb_first_n_clusters.sv
// tb/tb_first_n_clusters.sv - directed vector bench for first_n_clusters
module tb_first_n_clusters;
    import first_n_clusters_pkg::*;

    localparam int SB = 1536;
    localparam int NC = 8;
    localparam int AB = 11;
    localparam int CB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    first_n_clusters_if #(.MXSBITS(SB), .NCLUST(NC), .MXADRBITS(AB), .MXCNTBITS(CB)) bus ();
    first_n_clusters_if #(.MXSBITS(1024), .NCLUST(4), .MXADRBITS(AB), .MXCNTBITS(CB)) bus2 ();

    first_n_clusters #(.MXSBITS(SB), .NPART(2), .NCLUST(NC), .MXADRBITS(AB), .MXCNTBITS(CB)) dut (
        .clock4x(clk), .global_reset_n(rst_n),
        .latch_delay(bus.latch_delay), .latch_in(bus.latch_in),
        .vpfs_in(bus.vpfs), .cnts_in(bus.cnts),
        .adr_out(bus.adr), .cnt_out(bus.cnt), .vld_out(bus.vld),
        .done_out(bus.done), .latch_drop(bus.drop), .overflow(bus.overflow)
    );

    first_n_clusters #(.MXSBITS(1024), .NPART(4), .NCLUST(4), .MXADRBITS(AB), .MXCNTBITS(CB)) dut2 (
        .clock4x(clk), .global_reset_n(rst_n),
        .latch_delay(bus2.latch_delay), .latch_in(bus2.latch_in),
        .vpfs_in(bus2.vpfs), .cnts_in(bus2.cnts),
        .adr_out(bus2.adr), .cnt_out(bus2.cnt), .vld_out(bus2.vld),
        .done_out(bus2.done), .latch_drop(bus2.drop), .overflow(bus2.overflow)
    );

    typedef struct packed {
        logic [3:0]              delay;
        logic [3:0]              nbits;
        logic [9:0][10:0]        bidx;
        logic [9:0][2:0]         bcnt;
        logic [NC-1:0][AB-1:0]   eadr;
        logic [NC-1:0][CB-1:0]   ecnt;
        logic [NC-1:0]           evld;
        logic                    eovf;
        logic [4:0]              elat;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t vnew(input int d, input int lat);
        vec_t v;
        v = '0;
        v.delay = 4'(d);
        v.elat  = 5'(lat);
        v.eadr  = '1;
        return v;
    endfunction

    function automatic vec_t vbit(input vec_t vi, input int idx, input int c);
        vec_t v;
        v = vi;
        v.bidx[v.nbits] = 11'(idx);
        v.bcnt[v.nbits] = 3'(c);
        v.nbits = v.nbits + 4'd1;
        return v;
    endfunction

    function automatic vec_t vexp(input vec_t vi, input int slot, input int adr, input int c);
        vec_t v;
        v = vi;
        v.eadr[slot] = 11'(adr);
        v.ecnt[slot] = 3'(c);
        v.evld[slot] = 1'b1;
        return v;
    endfunction

    task automatic apply_bits(input vec_t v);
        bus.vpfs = '0;
        bus.cnts = '0;
        for (int k = 0; k < int'(v.nbits); k++) begin
            bus.vpfs[v.bidx[k]] = 1'b1;
            bus.cnts[int'(v.bidx[k])*CB +: CB] = v.bcnt[k];
        end
        bus.latch_delay = v.delay;
    endtask

    task automatic fire_and_wait(output int lat);
        bus.latch_in = 1'b1;
        @(posedge clk); #1;
        bus.latch_in = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        logic exp_ovf;
`ifdef FIRST_N_OVERFLOW_EN
        exp_ovf = v.eovf;
`else
        exp_ovf = 1'b0;
`endif
        apply_bits(v);
        fire_and_wait(lat);
        chk({tag, "_latency"}, 128'(lat), 128'(v.elat));
        chk({tag, "_adr"}, 128'(bus.adr), 128'(v.eadr));
        chk({tag, "_cnt"}, 128'(bus.cnt), 128'(v.ecnt));
        chk({tag, "_vld"}, 128'(bus.vld), 128'(v.evld));
        chk({tag, "_ovf"}, 128'(bus.overflow), 128'(exp_ovf));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 128'(bus.done), 128'(0));
        chk({tag, "_hold_vld"}, 128'(bus.vld), 128'(v.evld));
    endtask

    vec_t vecs[9];
    vec_t v;
    int lat, n_done, n_drop, done_at, drop_at, done2_at;
    logic [NC-1:0][AB-1:0] first_adr;

    initial begin
        bus.latch_delay = '0; bus.latch_in = 1'b0; bus.vpfs = '0; bus.cnts = '0;
        bus2.latch_delay = '0; bus2.latch_in = 1'b0; bus2.vpfs = '0; bus2.cnts = '0;

        v = vnew(0, 11); v = vbit(v, 5, 3); v = vbit(v, 900, 1);
        v = vexp(v, 0, 5, 3); v = vexp(v, 1, 900, 1); vecs[0] = v;
        v = vnew(0, 11);
        for (int i = 0; i < 10; i++) v = vbit(v, 10*i, i % 8);
        for (int s = 0; s < 8; s++) v = vexp(v, s, 10*s, s);
        v.eovf = 1'b1; vecs[1] = v;
        v = vnew(0, 11);
        v = vbit(v, 1, 2); v = vbit(v, 2, 2); v = vbit(v, 3, 2); v = vbit(v, 100, 2);
        v = vbit(v, 200, 2); v = vbit(v, 300, 2); v = vbit(v, 400, 2); v = vbit(v, 767, 2);
        v = vbit(v, 768, 5);
        v = vexp(v, 0, 1, 2); v = vexp(v, 1, 2, 2); v = vexp(v, 2, 3, 2); v = vexp(v, 3, 100, 2);
        v = vexp(v, 4, 200, 2); v = vexp(v, 5, 300, 2); v = vexp(v, 6, 400, 2); v = vexp(v, 7, 767, 2);
        v.eovf = 1'b1; vecs[2] = v;
        vecs[3] = vnew(0, 11);
        v = vnew(0, 11); v = vbit(v, 1535, 5); v = vbit(v, 768, 6); v = vbit(v, 767, 7);
        v = vexp(v, 0, 767, 7); v = vexp(v, 1, 768, 6); v = vexp(v, 2, 1535, 5); vecs[4] = v;
        v = vnew(5, 16); v = vbit(v, 42, 4); v = vexp(v, 0, 42, 4); vecs[5] = v;
        v = vnew(15, 26); v = vbit(v, 1000, 2); v = vexp(v, 0, 1000, 2); vecs[6] = v;
        v = vnew(0, 11);
        v = vbit(v, 790, 3); v = vbit(v, 20, 1); v = vbit(v, 780, 3); v = vbit(v, 10, 1); v = vbit(v, 770, 3);
        v = vexp(v, 0, 10, 1); v = vexp(v, 1, 20, 1); v = vexp(v, 2, 770, 3);
        v = vexp(v, 3, 780, 3); v = vexp(v, 4, 790, 3); vecs[7] = v;
        v = vnew(0, 11); v = vbit(v, 300, 1); v = vbit(v, 3, 2);
        v = vexp(v, 0, 3, 2); v = vexp(v, 1, 300, 1); vecs[8] = v;

        repeat (2) @(posedge clk); #1;
        chk("rst_adr", 128'(bus.adr), {40'd0, {NC*AB{1'b1}}});
        chk("rst_cnt", 128'(bus.cnt), 128'(0));
        chk("rst_vld", 128'(bus.vld), 128'(0));
        chk("rst_flags", 128'({bus.done, bus.drop, bus.overflow}), 128'(0));
        chk("rst2_adr", 128'(bus2.adr), 128'({4*AB{1'b1}}));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // second request lands mid-SCAN and must be dropped
        apply_bits(vecs[5]);
        bus.latch_in = 1'b1;
        @(posedge clk); #1;
        bus.latch_in = 1'b0;
        n_done = 0; n_drop = 0; done_at = -1; drop_at = -1;
        for (int c = 1; c <= 40; c++) begin
            bus.latch_in = (c == 8);
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin n_done++; done_at = c; end
            if (bus.drop === 1'b1) begin n_drop++; drop_at = c; end
        end
        bus.latch_in = 1'b0;
        chk("drop_count", 128'(n_drop), 128'(1));
        chk("drop_cycle", 128'(drop_at), 128'(13));
        chk("drop_done_count", 128'(n_done), 128'(1));
        chk("drop_done_cycle", 128'(done_at), 128'(16));
        chk("drop_adr0", 128'(bus.adr[AB-1:0]), 128'(42));

        // capture arriving in PUBLISH starts the next extraction back-to-back
        apply_bits(vecs[0]);
        bus.latch_in = 1'b1;
        @(posedge clk); #1;
        bus.latch_in = 1'b0;
        n_done = 0; n_drop = 0; done_at = -1; done2_at = -1; first_adr = '0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 11) begin
                bus.vpfs = '0; bus.cnts = '0;
                bus.vpfs[1535] = 1'b1; bus.cnts[1535*CB +: CB] = 3'd6;
            end
            bus.latch_in = (c == 11);
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                n_done++;
                if (done_at < 0) begin done_at = c; first_adr = bus.adr; end
                else done2_at = c;
            end
            if (bus.drop === 1'b1) n_drop++;
        end
        bus.latch_in = 1'b0;
        chk("b2b_done_count", 128'(n_done), 128'(2));
        chk("b2b_first_cycle", 128'(done_at), 128'(11));
        chk("b2b_second_cycle", 128'(done2_at), 128'(22));
        chk("b2b_no_drop", 128'(n_drop), 128'(0));
        chk("b2b_first_adr0", 128'(first_adr[0]), 128'(5));
        chk("b2b_second_adr0", 128'(bus.adr[AB-1:0]), 128'(1535));
        chk("b2b_second_cnt0", 128'(bus.cnt[CB-1:0]), 128'(6));
        chk("b2b_second_vld", 128'(bus.vld), 128'(8'h01));

        // reset while scanning aborts without publishing
        apply_bits(vecs[0]);
        bus.latch_in = 1'b1;
        @(posedge clk); #1;
        bus.latch_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_adr", 128'(bus.adr), {40'd0, {NC*AB{1'b1}}});
        chk("midrst_cnt", 128'(bus.cnt), 128'(0));
        chk("midrst_vld", 128'(bus.vld), 128'(0));
        chk("midrst_flags", 128'({bus.done, bus.drop, bus.overflow}), 128'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) n_done++;
        end
        chk("midrst_no_done", 128'(n_done), 128'(0));
        run_vec(vecs[0], "post_rst");

        // four-partition build, highest strip only
        bus2.vpfs = '0; bus2.cnts = '0;
        bus2.vpfs[1023] = 1'b1; bus2.cnts[1023*CB +: CB] = 3'd5;
        bus2.latch_delay = 4'd0;
        bus2.latch_in = 1'b1;
        @(posedge clk); #1;
        bus2.latch_in = 1'b0;
        lat = 0;
        while (bus2.done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("p4_latency", 128'(lat), 128'(9));
        chk("p4_adr", 128'(bus2.adr), 128'({11'h7FF, 11'h7FF, 11'h7FF, 11'd1023}));
        chk("p4_cnt", 128'(bus2.cnt), 128'({3'd0, 3'd0, 3'd0, 3'd5}));
        chk("p4_vld", 128'(bus2.vld), 128'(4'b0001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/first_n_clusters.md
FIRST_N_CLUSTERS -- requirements
Module: first_n_clusters

Interface
REQ-001 SHALL have parameter MXSBITS, default 1536: total S-bit inputs.
REQ-002 SHALL have parameter NPART, default 2: equal partitions; MXSBITS/NPART is an integer.
REQ-003 SHALL have parameter NCLUST, default 8: clusters reported per latch.
REQ-004 SHALL have parameters MXADRBITS, default 11, and MXCNTBITS, default 3: address and count widths; 2^MXADRBITS > MXSBITS.
REQ-005 SHALL have port clock4x, input, 1: the only clock.
REQ-006 SHALL have port global_reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port latch_delay, input, 4: extra cycles between latch_in and capture.
REQ-008 SHALL have port latch_in, input, 1: strobe that requests one extraction.
REQ-009 SHALL have port vpfs_in, input, MXSBITS: cluster-valid flags.
REQ-010 SHALL have port cnts_in, input, MXSBITS*MXCNTBITS: per-strip cluster size.
REQ-011 SHALL have port adr_out, output, NCLUST*MXADRBITS: cluster i in slice i, lowest address in slot 0.
REQ-012 SHALL have port cnt_out, output, NCLUST*MXCNTBITS: count for each slot.
REQ-013 SHALL have port vld_out, output, NCLUST: slot holds a real cluster.
REQ-014 SHALL have port done_out, output, 1: one-cycle pulse on the cycle outputs update.
REQ-015 SHALL have port latch_drop, output, 1: one-cycle pulse when a capture request is dropped.
REQ-016 SHALL have port overflow, output, 1: more than NCLUST clusters were present.

Function
REQ-017 SHALL delay latch_in through a 16-deep shift register; capture request = tap latch_delay (0 → same edge latch_in sampled).
REQ-018 SHALL use states IDLE, SCAN, MERGE, PUBLISH; IDLE→SCAN on capture request.
REQ-019 SHALL snapshot vpfs_in and cnts_in on capture into per-partition working registers.
REQ-020 SCAN SHALL last exactly NCLUST cycles; each cycle each partition encodes its lowest set bit, records local index, count and found flag, then clears that bit.
REQ-021 SHALL form global address = partition index*(MXSBITS/NPART) + local index, truncated to MXADRBITS.
REQ-022 MERGE SHALL last exactly NPART cycles, appending partition p's found entries in order (p=0 first) and keeping only the first NCLUST.
REQ-023 PUBLISH SHALL be 1 cycle: register adr_out/cnt_out/vld_out, pulse done_out, then →IDLE.
REQ-024 Latency SHALL be fixed: outputs update at capture edge + NCLUST + NPART + 1 (defaults: 11).
REQ-025 Empty slots SHALL read adr all-ones, cnt 0, vld 0.
REQ-026 A capture request in SCAN or MERGE SHALL be ignored and pulse latch_drop; one in PUBLISH SHALL be accepted (→SCAN, back-to-back).
REQ-027 Outputs SHALL hold their values between done_out pulses.
REQ-028 vpfs all zero SHALL publish all slots empty with done_out pulsed.

Reset
REQ-029 Reset SHALL clear the shift register, working registers and state (→IDLE), set adr_out all-ones, cnt_out 0, vld_out 0, done_out/latch_drop/overflow 0.
REQ-030 Reset mid-SCAN/MERGE SHALL abort without pulsing done_out; first capture after release proceeds normally.

Configuration
REQ-031 With FIRST_N_OVERFLOW_EN defined, overflow SHALL register with PUBLISH, high if any working bit remains after SCAN or merged found entries exceed NCLUST, else low.
REQ-032 Without FIRST_N_OVERFLOW_EN, overflow SHALL be constant 0 and no detection logic built.

Structure
REQ-033 A shared package SHALL hold the state enum, default parameter values and the empty-address constant.
REQ-034 SHALL use one sub-module, partition_scanner: the per-partition iterative find-first-and-clear encoder, instantiated NPART times.

Verification
REQ-035 Bits 5 and 900, cnt 3 and 1, latch_delay 0 → done_out at +11; slot0 adr 5/cnt 3, slot1 adr 900/cnt 1, slots 2-7 empty.
REQ-036 Bits 0,10,…,90 set, strap FIRST_N_OVERFLOW_EN → slots hold 0..70; overflow 1.
REQ-037 Partition 0 holds 8 bits, partition 1 holds bit 768 → partition-0 bits only; bit 768 excluded.
REQ-038 latch_delay 5 → done_out at +16; second latch_in 3 cycles after first capture → latch_drop pulse, no extra done_out.
REQ-039 global_reset_n low during SCAN → all outputs at reset values, no done_out; latch after release → correct result at +11.
REQ-040 NPART 4, MXSBITS 1024, NCLUST 4, bit 1023 only → slot0 adr 1023, done_out at capture + 9.
